// File: rtl/core101_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and default bus widths.
package core101_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_IFU = 2'd1,
      BUSY_LSU = 2'd2,
      RESP     = 2'd3
   } arb_state_e;

   localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
   localparam int unsigned DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of back-to-back LSU grants taken while the IFU waits; raises
// i_ifu_req-qualified o_ifu_force once the streak limit is reached.
module arb_streak_counter
   import core101_pkg::*;
#(
   parameter int unsigned MAX_STREAK = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_ifu_req,
   input  logic i_lsu_grant,
   input  logic i_ifu_grant,
   output logic o_ifu_force
);

   localparam logic [3:0] MaxStreak = 4'(MAX_STREAK);

   logic [3:0] r_streak;
   logic [3:0] w_streak_next;

   always_comb begin
      w_streak_next = r_streak;
      if (i_ifu_grant) begin
         w_streak_next = 4'd0;
      end else if (i_lsu_grant) begin
         if (!i_ifu_req) begin
            w_streak_next = 4'd0;
         end else if (r_streak != MaxStreak) begin
            w_streak_next = r_streak + 4'd1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_streak <= 4'd0;
      end else begin
         r_streak <= w_streak_next;
      end
   end

   assign o_ifu_force = i_ifu_req && (r_streak == MaxStreak);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for the single main-memory port, LSU priority with
// an IFU starvation guard. Optional BUSY watchdog enabled by MEM_TIMEOUT_EN.
module mem_arbiter
   import core101_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int unsigned MAX_LSU_STREAK = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clock_in,
   input  logic                  reset_in,
   input  logic                  ifu_req_in,
   input  logic [ADDR_WIDTH-1:0] ifu_addr_in,
   output logic                  ifu_gnt_out,
   output logic                  ifu_valid_out,
   output logic [DATA_WIDTH-1:0] ifu_rdata_out,
   input  logic                  lsu_req_in,
   input  logic                  lsu_we_in,
   input  logic [ADDR_WIDTH-1:0] lsu_addr_in,
   input  logic [DATA_WIDTH-1:0] lsu_wdata_in,
   output logic                  lsu_gnt_out,
   output logic                  lsu_valid_out,
   output logic [DATA_WIDTH-1:0] lsu_rdata_out,
   output logic [ADDR_WIDTH-1:0] mem_addr_out,
   output logic [DATA_WIDTH-1:0] mem_wdata_out,
   output logic                  mem_read_out,
   output logic                  mem_write_out,
   input  logic [DATA_WIDTH-1:0] mem_rdata_in,
   input  logic                  mem_valid_in,
   output logic                  err_timeout_out
);

   arb_state_e            r_state, w_state_next;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic                  r_mem_read, r_mem_write;
   logic [DATA_WIDTH-1:0] r_ifu_rdata, r_lsu_rdata;
   logic                  r_ifu_valid, r_lsu_valid, r_err;

   logic w_ifu_force, w_lsu_win, w_idle, w_busy, w_grant, w_finish, w_abort;

   assign w_idle    = (r_state == IDLE);
   assign w_busy    = (r_state == BUSY_IFU) || (r_state == BUSY_LSU);
   assign w_lsu_win = lsu_req_in && !w_ifu_force;
   assign w_grant   = w_idle && (lsu_req_in || ifu_req_in);
   assign w_finish  = w_busy && (mem_valid_in || w_abort);

   arb_streak_counter #(
      .MAX_STREAK (MAX_LSU_STREAK)
   ) u_streak (
      .i_clk       (clock_in),
      .i_rst       (reset_in),
      .i_ifu_req   (ifu_req_in),
      .i_lsu_grant (w_grant && w_lsu_win),
      .i_ifu_grant (w_grant && !w_lsu_win),
      .o_ifu_force (w_ifu_force)
   );

`ifdef MEM_TIMEOUT_EN
   logic [7:0] r_tcnt;

   // Held at zero outside BUSY, so every BUSY entry starts a fresh count.
   always_ff @(posedge clock_in) begin
      if (reset_in || !w_busy) begin
         r_tcnt <= 8'd0;
      end else if (!mem_valid_in) begin
         r_tcnt <= r_tcnt + 8'd1;
      end
   end

   assign w_abort = w_busy && !mem_valid_in && (r_tcnt == 8'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
   assign w_abort          = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_lsu_win)       w_state_next = BUSY_LSU;
            else if (ifu_req_in) w_state_next = BUSY_IFU;
         end
         BUSY_IFU, BUSY_LSU: begin
            if (mem_valid_in || w_abort) w_state_next = RESP;
         end
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         r_state     <= IDLE;
         r_we        <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_ifu_rdata <= '0;
         r_lsu_rdata <= '0;
         r_ifu_valid <= 1'b0;
         r_lsu_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_ifu_valid <= 1'b0;
         r_lsu_valid <= 1'b0;
         r_err       <= 1'b0;
         if (w_grant) begin
            r_we        <= w_lsu_win && lsu_we_in;
            r_mem_addr  <= w_lsu_win ? lsu_addr_in : ifu_addr_in;
            r_mem_wdata <= w_lsu_win ? lsu_wdata_in : '0;
            r_mem_read  <= !(w_lsu_win && lsu_we_in);
            r_mem_write <= w_lsu_win && lsu_we_in;
         end
         if (w_finish) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_err       <= w_abort;
            if (r_state == BUSY_LSU) begin
               r_lsu_valid <= 1'b1;
               if (w_abort)    r_lsu_rdata <= '0;
               else if (!r_we) r_lsu_rdata <= mem_rdata_in;
            end else begin
               r_ifu_valid <= 1'b1;
               r_ifu_rdata <= w_abort ? '0 : mem_rdata_in;
            end
         end
      end
   end

   assign ifu_gnt_out     = (r_state == BUSY_IFU);
   assign lsu_gnt_out     = (r_state == BUSY_LSU);
   assign ifu_valid_out   = r_ifu_valid;
   assign lsu_valid_out   = r_lsu_valid;
   assign ifu_rdata_out   = r_ifu_rdata;
   assign lsu_rdata_out   = r_lsu_rdata;
   assign mem_addr_out    = r_mem_addr;
   assign mem_wdata_out   = r_mem_wdata;
   assign mem_read_out    = r_mem_read;
   assign mem_write_out   = r_mem_write;
   assign err_timeout_out = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the watchdog steps run only when MEM_TIMEOUT_EN is defined.
module tb_mem_arbiter;

   logic        clock_in = 1'b0;
   logic        reset_in;
   logic        ifu_req_in, lsu_req_in, lsu_we_in, mem_valid_in;
   logic [31:0] ifu_addr_in, lsu_addr_in, lsu_wdata_in, mem_rdata_in;
   logic        ifu_gnt_out, ifu_valid_out, lsu_gnt_out, lsu_valid_out;
   logic        mem_read_out, mem_write_out, err_timeout_out;
   logic [31:0] ifu_rdata_out, lsu_rdata_out, mem_addr_out, mem_wdata_out;

   int errors = 0;
   int checks = 0;

   mem_arbiter dut (
      .clock_in        (clock_in),
      .reset_in        (reset_in),
      .ifu_req_in      (ifu_req_in),
      .ifu_addr_in     (ifu_addr_in),
      .ifu_gnt_out     (ifu_gnt_out),
      .ifu_valid_out   (ifu_valid_out),
      .ifu_rdata_out   (ifu_rdata_out),
      .lsu_req_in      (lsu_req_in),
      .lsu_we_in       (lsu_we_in),
      .lsu_addr_in     (lsu_addr_in),
      .lsu_wdata_in    (lsu_wdata_in),
      .lsu_gnt_out     (lsu_gnt_out),
      .lsu_valid_out   (lsu_valid_out),
      .lsu_rdata_out   (lsu_rdata_out),
      .mem_addr_out    (mem_addr_out),
      .mem_wdata_out   (mem_wdata_out),
      .mem_read_out    (mem_read_out),
      .mem_write_out   (mem_write_out),
      .mem_rdata_in    (mem_rdata_in),
      .mem_valid_in    (mem_valid_in),
      .err_timeout_out (err_timeout_out)
   );

   always #5 clock_in = ~clock_in;

   task automatic step();
      @(posedge clock_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {57'd0, ifu_gnt_out, ifu_valid_out, lsu_gnt_out, lsu_valid_out,
                          mem_read_out, mem_write_out, err_timeout_out}, 64'd0);
      chk({tag, "_rdata"}, {ifu_rdata_out, lsu_rdata_out}, 64'd0);
      chk({tag, "_mem"}, {mem_addr_out, mem_wdata_out}, 64'd0);
   endtask

   // Waits (bounded) for a grant, answers with a one-cycle memory completion, checks the owner.
   task automatic serve(input logic exp_lsu, input string tag);
      int n = 0;
      while (!(ifu_gnt_out || lsu_gnt_out) && n < 8) begin
         step();
         n++;
      end
      chk({tag, "_gnt"}, {62'd0, ifu_gnt_out, lsu_gnt_out}, {62'd0, !exp_lsu, exp_lsu});
      mem_valid_in = 1'b1;
      mem_rdata_in = 32'h1357_9BDF;
      step();
      mem_valid_in = 1'b0;
      chk({tag, "_vld"}, {62'd0, ifu_valid_out, lsu_valid_out}, {62'd0, !exp_lsu, exp_lsu});
      step();
   endtask

   initial begin
      logic ok;
      int   busy;
      reset_in = 1'b1;
      ifu_req_in = 1'b0; ifu_addr_in = '0;
      lsu_req_in = 1'b0; lsu_we_in = 1'b0; lsu_addr_in = '0; lsu_wdata_in = '0;
      mem_valid_in = 1'b0; mem_rdata_in = '0;
      step();
      step();
      reset_in = 1'b0;
      chk_all_zero("por");

      // Single IFU read, memory answers in cycle 3
      ifu_req_in = 1'b1; ifu_addr_in = 32'h0000_0008;
      step();
      chk("ifu_c1", {mem_read_out, ifu_gnt_out, mem_write_out, mem_addr_out}, {3'b110, 32'h8});
      step();
      chk("ifu_c2_rd", mem_read_out, 1'b1);
      step();
      chk("ifu_c3_rd", {mem_read_out, ifu_valid_out}, 2'b10);
      mem_valid_in = 1'b1; mem_rdata_in = 32'h00A0_0093;
      step();
      mem_valid_in = 1'b0; ifu_req_in = 1'b0;
      chk("ifu_c4", {ifu_valid_out, mem_read_out, ifu_rdata_out}, {2'b10, 32'h00A0_0093});
      step();
      chk("ifu_c5", {ifu_valid_out, ifu_gnt_out}, 2'b00);

      // Collision: LSU write wins, IFU follows at the next IDLE
      ifu_req_in = 1'b1; ifu_addr_in = 32'h200;
      lsu_req_in = 1'b1; lsu_we_in = 1'b1; lsu_addr_in = 32'h100; lsu_wdata_in = 32'hDEAD_BEEF;
      step();
      chk("col_lsu_gnt", {ifu_gnt_out, lsu_gnt_out, mem_read_out, mem_write_out}, 4'b0101);
      chk("col_wr_bus", {mem_addr_out, mem_wdata_out}, {32'h100, 32'hDEAD_BEEF});
      mem_valid_in = 1'b1; mem_rdata_in = 32'hFFFF_FFFF;
      step();
      mem_valid_in = 1'b0; lsu_req_in = 1'b0; lsu_we_in = 1'b0;
      chk("col_lsu_vld", {lsu_valid_out, mem_write_out, lsu_rdata_out}, {2'b10, 32'h0});
      step();
      step();
      chk("col_ifu_gnt", {ifu_gnt_out, mem_read_out, mem_addr_out}, {2'b11, 32'h200});
      mem_valid_in = 1'b1; mem_rdata_in = 32'h1111_2222;
      step();
      mem_valid_in = 1'b0;
      chk("col_ifu_vld", {ifu_valid_out, ifu_rdata_out}, {1'b1, 32'h1111_2222});
      lsu_req_in = 1'b1; lsu_addr_in = 32'h400;

      // Starvation guard: four LSU grants, one IFU, then LSU again
      step();
      serve(1'b1, "stv0");
      serve(1'b1, "stv1");
      serve(1'b1, "stv2");
      serve(1'b1, "stv3");
      serve(1'b0, "stv4");
      serve(1'b1, "stv5");
      ifu_req_in = 1'b0; lsu_req_in = 1'b0;

      // mem_valid outside BUSY must be ignored
      mem_valid_in = 1'b1; mem_rdata_in = 32'hBAD0_BAD0;
      step();
      mem_valid_in = 1'b0;
      step();
      chk("stray_valid", {ifu_gnt_out, lsu_gnt_out, ifu_valid_out, lsu_valid_out}, 4'b0000);

      // Slow memory, LSU read; request drops right after grant
      lsu_req_in = 1'b1; lsu_we_in = 1'b0; lsu_addr_in = 32'h40;
      step();
      lsu_req_in = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ok &= lsu_gnt_out && mem_read_out && !mem_write_out && !lsu_valid_out && !err_timeout_out
               && (mem_addr_out == 32'h40);
         step();
      end
      chk("slow_held", ok, 1'b1);
      mem_valid_in = 1'b1; mem_rdata_in = 32'hCAFE_F00D;
      step();
      mem_valid_in = 1'b0;
      chk("slow_vld", {lsu_valid_out, err_timeout_out, lsu_rdata_out}, {2'b10, 32'hCAFE_F00D});
      step();
      chk("slow_single", {lsu_valid_out, lsu_gnt_out, mem_read_out}, 3'b000);

`ifdef MEM_TIMEOUT_EN
      ifu_req_in = 1'b1; ifu_addr_in = 32'h80;
      step();
      ifu_req_in = 1'b0;
      busy = 0;
      while (ifu_gnt_out && busy < 40) begin
         busy++;
         step();
      end
      chk("to_busy_cycles", 64'(busy), 64'd16);
      chk("to_resp", {ifu_valid_out, err_timeout_out, ifu_rdata_out}, {2'b11, 32'h0});
      step();
      chk("to_err_pulse", {ifu_valid_out, err_timeout_out}, 2'b00);
      ifu_req_in = 1'b1;
      serve(1'b0, "to_after");
      ifu_req_in = 1'b0;
      chk("to_after_data", {err_timeout_out, ifu_rdata_out}, {1'b0, 32'h1357_9BDF});
`else
      busy = 0;
`endif

      // Reset mid BUSY_LSU write
      lsu_req_in = 1'b1; lsu_we_in = 1'b1; lsu_addr_in = 32'h300; lsu_wdata_in = 32'h55;
      step();
      chk("rst_pre", {lsu_gnt_out, mem_write_out}, 2'b11);
      reset_in = 1'b1; lsu_req_in = 1'b0; lsu_we_in = 1'b0;
      step();
      step();
      reset_in = 1'b0;
      chk_all_zero("rst_mid");
      step();
      chk_all_zero("rst_after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
